// File: rtl/cam_pkg.sv
// Shared defaults and encodings for the CAM request controller.
package cam_pkg;

  localparam int DEFAULT_DEPTH  = 32;
  localparam int DEFAULT_KEY_W  = 8;
  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OP_SEARCH = 1'b0,
    OP_WRITE  = 1'b1
  } op_t;

endpackage

// File: rtl/cam_valid_map.sv
// Per-entry valid bitmap with write-set, flush-clear and population count.
module cam_valid_map
  import cam_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic              o_lookup_hit,
  output logic [ADDR_W:0]   o_occupancy
);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  w_set_mask;
  logic [DEPTH-1:0]  w_next;
  logic [ADDR_W:0]   w_count;
  logic [DEPTH-1:0]  w_one;

  assign w_one = {{(DEPTH-1){1'b0}}, 1'b1};

  // Flush clears first so a coincident write still lands in the map.
  always_comb begin
    w_set_mask = i_set ? (w_one << i_set_addr) : {DEPTH{1'b0}};
    w_next     = (i_flush ? {DEPTH{1'b0}} : r_valid) | w_set_mask;
  end

  // Valid bitmap register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= {DEPTH{1'b0}};
    end else begin
      r_valid <= w_next;
    end
  end

  // Population count of valid entries.
  always_comb begin
    w_count = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + (ADDR_W+1)'(r_valid[i]);
    end
  end

  // A flush on the sampling edge means the lookup sees an empty map.
  assign o_lookup_hit = r_valid[i_lookup_addr] & ~i_flush;
  assign o_occupancy  = w_count;

endmodule

// File: rtl/cam_ctrl.sv
// Request/response sequencer for an external CAM with a registered match port.
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int KEY_W  = DEFAULT_KEY_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [KEY_W-1:0]  req_key,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_hit,
  output logic [ADDR_W:0]   occupancy,
  output logic              cam_enable,
  output logic              cam_write,
  output logic [ADDR_W-1:0] cam_addr,
  output logic [KEY_W-1:0]  cam_data,
  input  logic [ADDR_W-1:0] cam_out
);

  state_t            r_state;
  op_t               r_op;
  logic              r_req_ready;
  logic              r_res_valid;
  logic              r_res_hit;
  logic [ADDR_W-1:0] r_res_addr;
  logic              r_cam_enable;
  logic              r_cam_write;
  logic [ADDR_W-1:0] r_cam_addr;
  logic [KEY_W-1:0]  r_cam_data;
  logic              w_set;
  logic              w_lookup_hit;

  assign w_set = (r_state == ST_ISSUE) && (r_op == OP_WRITE);

  cam_valid_map #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_valid_map (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (flush),
    .i_set         (w_set),
    .i_set_addr    (r_cam_addr),
    .i_lookup_addr (cam_out),
    .o_lookup_hit  (w_lookup_hit),
    .o_occupancy   (occupancy)
  );

  // Controller FSM; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_SEARCH;
      r_req_ready  <= 1'b1;
      r_res_valid  <= 1'b0;
      r_res_hit    <= 1'b0;
      r_res_addr   <= {ADDR_W{1'b0}};
      r_cam_enable <= 1'b0;
      r_cam_write  <= 1'b0;
      r_cam_addr   <= {ADDR_W{1'b0}};
      r_cam_data   <= {KEY_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op         <= op_t'(req_op);
            r_cam_data   <= req_key;
            r_cam_addr   <= req_addr;
            r_cam_enable <= 1'b1;
            r_cam_write  <= req_op;
            r_req_ready  <= 1'b0;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_op == OP_WRITE) begin
            r_cam_enable <= 1'b0;
            r_cam_write  <= 1'b0;
            r_res_valid  <= 1'b1;
            r_res_addr   <= r_cam_addr;
            r_res_hit    <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_cam_write  <= 1'b0;
            r_state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cam_enable <= 1'b0;
          r_res_valid  <= 1'b1;
          r_res_addr   <= cam_out;
          r_res_hit    <= w_lookup_hit;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_cam_enable <= 1'b0;
          r_cam_write  <= 1'b0;
          r_res_valid  <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign res_valid  = r_res_valid;
  assign res_hit    = r_res_hit;
  assign res_addr   = r_res_addr;
  assign cam_enable = r_cam_enable;
  assign cam_write  = r_cam_write;
  assign cam_addr   = r_cam_addr;
  assign cam_data   = r_cam_data;

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed self-checking bench for cam_ctrl.
module tb_cam_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic [7:0] req_key;
  logic [4:0] req_addr;
  logic       flush;
  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_addr;
  logic       res_hit;
  logic [5:0] occupancy;
  logic       cam_enable;
  logic       cam_write;
  logic [4:0] cam_addr;
  logic [7:0] cam_data;
  logic [4:0] cam_out;

  int n_checks;
  int n_fail;

  cam_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_key    (req_key),
    .req_addr   (req_addr),
    .flush      (flush),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_addr   (res_addr),
    .res_hit    (res_hit),
    .occupancy  (occupancy),
    .cam_enable (cam_enable),
    .cam_write  (cam_write),
    .cam_addr   (cam_addr),
    .cam_data   (cam_data),
    .cam_out    (cam_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic op, input logic [7:0] key, input logic [4:0] addr);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({res_valid, res_hit, res_addr, cam_enable, cam_write, cam_addr, cam_data} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {res_valid, res_hit, res_addr, cam_enable, cam_write, cam_addr, cam_data});
    end
    n_checks++;
    if (occupancy !== 6'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    rst = 1'b0;
    tick();
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_write();
    start_req(1'b1, 8'd5, 5'd3);
    n_checks++;
    if ({cam_enable, cam_write, cam_addr, cam_data, req_ready, res_valid} !== {1'b1, 1'b1, 5'd3, 8'd5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL write_issue: en=%b wr=%b addr=%0d data=%0d rdy=%b rv=%b want 1 1 3 5 0 0",
               cam_enable, cam_write, cam_addr, cam_data, req_ready, res_valid);
    end
    tick();
    n_checks++;
    if ({res_valid, res_addr, res_hit, cam_write, cam_enable} !== {1'b1, 5'd3, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL write_resp: rv=%b addr=%0d hit=%b wr=%b en=%b want 1 3 1 0 0",
               res_valid, res_addr, res_hit, cam_write, cam_enable);
    end
    n_checks++;
    if (occupancy !== 6'd1) begin n_fail++; $display("FAIL write_occ: got %0d want 1", occupancy); end
    tick();
    n_checks++;
    if ({res_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL write_idle: rv=%b rdy=%b want 0 1", res_valid, req_ready);
    end
  endtask

  task automatic test_search_hit();
    start_req(1'b0, 8'd5, 5'd0);
    n_checks++;
    if ({cam_enable, cam_write, cam_data} !== {1'b1, 1'b0, 8'd5}) begin
      n_fail++; $display("FAIL search_issue: en=%b wr=%b data=%0d want 1 0 5", cam_enable, cam_write, cam_data);
    end
    cam_out = 5'd3;
    tick();
    n_checks++;
    if ({cam_enable, cam_write, cam_data, res_valid} !== {1'b1, 1'b0, 8'd5, 1'b0}) begin
      n_fail++; $display("FAIL search_wait: en=%b wr=%b data=%0d rv=%b want 1 0 5 0",
                         cam_enable, cam_write, cam_data, res_valid);
    end
    tick();
    n_checks++;
    if ({res_valid, res_addr, res_hit, cam_enable} !== {1'b1, 5'd3, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL search_hit_resp: rv=%b addr=%0d hit=%b en=%b want 1 3 1 0",
                         res_valid, res_addr, res_hit, cam_enable);
    end
    tick();
  endtask

  task automatic test_search_miss();
    start_req(1'b0, 8'd3, 5'd0);
    cam_out = 5'd0;
    tick();
    tick();
    n_checks++;
    if ({res_valid, res_addr, res_hit} !== {1'b1, 5'd0, 1'b0}) begin
      n_fail++; $display("FAIL search_miss: rv=%b addr=%0d hit=%b want 1 0 0", res_valid, res_addr, res_hit);
    end
    tick();
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    start_req(1'b1, 8'hA5, 5'd7);
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({res_valid, res_addr, res_hit, req_ready} !== {1'b1, 5'd7, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL hold_%0d: rv=%b addr=%0d hit=%b rdy=%b want 1 7 1 0",
                           i, res_valid, res_addr, res_hit, req_ready);
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    n_checks++;
    if ({res_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL hold_release: rv=%b rdy=%b want 0 1", res_valid, req_ready);
    end
    n_checks++;
    if (occupancy !== 6'd2) begin n_fail++; $display("FAIL hold_occ: got %0d want 2", occupancy); end
  endtask

  task automatic test_rewrite();
    start_req(1'b1, 8'd6, 5'd3);
    tick();
    n_checks++;
    if (occupancy !== 6'd2) begin n_fail++; $display("FAIL rewrite_occ: got %0d want 2", occupancy); end
    tick();
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1;
    req_op    = 1'b1;
    req_key   = 8'h11;
    for (int c = 0; c < 9; c++) begin
      n_checks++;
      if ({req_ready, res_valid} !== {(c % 3) == 0, (c % 3) == 2}) begin
        n_fail++; $display("FAIL b2b_cycle_%0d: rdy=%b rv=%b want %b %b",
                           c, req_ready, res_valid, (c % 3) == 0, (c % 3) == 2);
      end
      if ((c % 3) == 0) req_addr = 5'(20 + c / 3);
      tick();
    end
    req_valid = 1'b0;
    n_checks++;
    if (occupancy !== 6'd5) begin n_fail++; $display("FAIL b2b_occ: got %0d want 5", occupancy); end
  endtask

  task automatic test_flush_wait();
    start_req(1'b0, 8'd5, 5'd0);
    cam_out = 5'd3;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if ({res_valid, res_addr, res_hit} !== {1'b1, 5'd3, 1'b0}) begin
      n_fail++; $display("FAIL flush_wait: rv=%b addr=%0d hit=%b want 1 3 0", res_valid, res_addr, res_hit);
    end
    n_checks++;
    if (occupancy !== 6'd0) begin n_fail++; $display("FAIL flush_wait_occ: got %0d want 0", occupancy); end
    tick();
  endtask

  task automatic test_flush_write();
    start_req(1'b1, 8'd9, 5'd9);
    tick();
    tick();
    start_req(1'b1, 8'd12, 5'd12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if ({occupancy, res_hit, res_addr} !== {6'd1, 1'b1, 5'd12}) begin
      n_fail++; $display("FAIL flush_write: occ=%0d hit=%b addr=%0d want 1 1 12", occupancy, res_hit, res_addr);
    end
    tick();
    start_req(1'b0, 8'd9, 5'd0);
    cam_out = 5'd9;
    tick();
    tick();
    n_checks++;
    if ({res_addr, res_hit} !== {5'd9, 1'b0}) begin
      n_fail++; $display("FAIL flushed_entry: addr=%0d hit=%b want 9 0", res_addr, res_hit);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start_req(1'b0, 8'd12, 5'd4);
    cam_out = 5'd12;
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({res_valid, res_hit, res_addr, cam_enable, cam_write, cam_addr, cam_data, occupancy} !== 26'h0) begin
      n_fail++; $display("FAIL async_reset: got %h want 0",
                         {res_valid, res_hit, res_addr, cam_enable, cam_write, cam_addr, cam_data, occupancy});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({res_valid, req_ready} !== 2'b01) begin
        n_fail++; $display("FAIL post_reset_%0d: rv=%b rdy=%b want 0 1", i, res_valid, req_ready);
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_key   = 8'd0;
    req_addr  = 5'd0;
    flush     = 1'b0;
    res_ready = 1'b1;
    cam_out   = 5'd0;
    test_reset();
    test_write();
    test_search_hit();
    test_search_miss();
    test_backpressure();
    test_rewrite();
    test_back_to_back();
    test_flush_wait();
    test_flush_write();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
